// File: rtl/arb_pkg.sv
// Shared types and sizes for the four-requester priority arbiter.
// Holds the FSM state encoding and the index-to-one-hot helper.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/arb_pick_encoder.sv
// Combinational winner picker: searches offset-1, offset-2, offset-3, offset (mod 4).
// An offset of zero yields plain fixed priority 3 > 2 > 1 > 0.
module arb_pick_encoder
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   offset,
    output logic               any,
    output logic [IDX_W-1:0]   winner
);

    logic [IDX_W-1:0] cand;

    // Walk the search order backwards so the earliest candidate in the order wins.
    always_comb begin
        any    = |req;
        winner = '0;
        cand   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = offset - k[IDX_W-1:0];
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/priority_arbiter_4.sv
// Four-requester arbiter with grant hold, done/withdraw release and MAX_HOLD timeout.
// Define ARB_ROUND_ROBIN_EN to build the rotating-priority pointer; default is fixed priority.
module priority_arbiter_4
    import arb_pkg::*;
#(
    parameter  int MAX_HOLD = 16,
    localparam int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_id,
    output logic               timeout
);

    arb_state_t         state;
    arb_state_t         state_next;
    logic [NUM_REQ-1:0] gnt_next;
    logic [IDX_W-1:0]   gnt_id_next;
    logic               timeout_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               pick_any;
    logic [IDX_W-1:0]   pick_winner;
    logic [IDX_W-1:0]   offset;
    logic               hold_max;
    logic               released;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_next;

    assign offset = ptr;
`else
    assign offset = '0;
`endif

    arb_pick_encoder u_pick (
        .req    (req),
        .offset (offset),
        .any    (pick_any),
        .winner (pick_winner)
    );

    assign hold_max  = (cnt == CNT_W'(MAX_HOLD));
    assign released  = done | ~req[gnt_id] | hold_max;
    assign gnt_valid = |gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            timeout <= 1'b0;
            cnt     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr     <= '0;
`endif
        end else begin
            state   <= state_next;
            gnt     <= gnt_next;
            gnt_id  <= gnt_id_next;
            timeout <= timeout_next;
            cnt     <= cnt_next;
`ifdef ARB_ROUND_ROBIN_EN
            ptr     <= ptr_next;
`endif
        end
    end

    // timeout only flags a pure forced release; done or a withdrawn request masks it.
    always_comb begin
        state_next   = state;
        gnt_next     = gnt;
        gnt_id_next  = gnt_id;
        timeout_next = 1'b0;
        cnt_next     = cnt;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_next     = ptr;
`endif
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_next  = GRANT;
                    gnt_next    = idx_to_onehot(pick_winner);
                    gnt_id_next = pick_winner;
                    cnt_next    = CNT_W'(1);
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_next    = pick_winner;
`endif
                end
            end
            GRANT: begin
                if (released) begin
                    state_next   = IDLE;
                    gnt_next     = '0;
                    gnt_id_next  = '0;
                    cnt_next     = '0;
                    timeout_next = hold_max & ~done & req[gnt_id];
                end else if (!hold_max) begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
